// File: rtl/hyperbus_cfg_pkg.sv
// Shared types for the HyperBus configuration-port arbiter.
// The request struct is sized for the widest supported bus (64-bit address,
// 64-bit data); instances with narrower buses use the low bits of each field.
package hyperbus_cfg_pkg;

   localparam int CFG_MAX_ADDR_WIDTH = 64;
   localparam int CFG_MAX_DATA_WIDTH = 64;
   localparam int CFG_MAX_STRB_WIDTH = CFG_MAX_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } cfg_state_t;

   typedef struct packed {
      logic [CFG_MAX_ADDR_WIDTH-1:0] addr;
      logic                          write;
      logic [CFG_MAX_DATA_WIDTH-1:0] wdata;
      logic [CFG_MAX_STRB_WIDTH-1:0] wstrb;
   } cfg_req_t;

endpackage

// File: rtl/hyperbus_cfg_rr_arb.sv
// Combinational round-robin grant: the search starts at the port after
// last_grant and wraps, so the port served most recently has lowest priority.
module hyperbus_cfg_rr_arb #(
   parameter int NR_PORTS = 2,
   parameter int IDX_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
   input  logic [NR_PORTS-1:0] req,
   input  logic [IDX_W-1:0]    last_grant,
   output logic [NR_PORTS-1:0] grant,
   output logic [IDX_W-1:0]    grant_idx
);

   logic [IDX_W-1:0] cand;
   logic             found;

   // Walk the ports in rotated order and take the first one requesting
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      for (int i = 1; i <= NR_PORTS; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % NR_PORTS);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hyperbus_cfg_arbiter.sv
// Arbitrates several config-bus requesters onto the single HyperBus macro
// cfg port, one access at a time, round-robin between ports.
// Optional feature: define HYPERBUS_CFG_TIMEOUT_EN to abort a downstream
// access that stays outstanding for TIMEOUT_CYCLES cycles.
// ADDR_WIDTH and DATA_WIDTH are limited to 64 by the package request struct.
module hyperbus_cfg_arbiter
   import hyperbus_cfg_pkg::*;
#(
   parameter int NR_PORTS       = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk_sys_i,
   input  logic                           rst_i,
   input  logic [NR_PORTS*ADDR_WIDTH-1:0] s_addr_i,
   input  logic [NR_PORTS-1:0]            s_write_i,
   input  logic [NR_PORTS*DATA_WIDTH-1:0] s_wdata_i,
   input  logic [NR_PORTS*(DATA_WIDTH/8)-1:0] s_wstrb_i,
   input  logic [NR_PORTS-1:0]            s_valid_i,
   output logic [NR_PORTS*DATA_WIDTH-1:0] s_rdata_o,
   output logic [NR_PORTS-1:0]            s_error_o,
   output logic [NR_PORTS-1:0]            s_ready_o,
   output logic [ADDR_WIDTH-1:0]          m_addr_o,
   output logic                           m_write_o,
   output logic [DATA_WIDTH-1:0]          m_wdata_o,
   output logic [DATA_WIDTH/8-1:0]        m_wstrb_o,
   output logic                           m_valid_o,
   input  logic [DATA_WIDTH-1:0]          m_rdata_i,
   input  logic                           m_error_i,
   input  logic                           m_ready_i,
   output logic                           timeout_o
);

   localparam int SW    = DATA_WIDTH / 8;
   localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

   cfg_state_t            state_q, state_d;
   cfg_req_t              req_q;
   logic [IDX_W-1:0]      last_grant_q;
   logic [IDX_W-1:0]      arb_idx;
   logic [NR_PORTS-1:0]   arb_onehot;
   logic [DATA_WIDTH-1:0] resp_rdata_q;
   logic                  resp_error_q;
   logic                  timeout_hit;
   logic                  unused_bits;

   hyperbus_cfg_rr_arb #(
      .NR_PORTS (NR_PORTS),
      .IDX_W    (IDX_W)
   ) u_rr_arb (
      .req        (s_valid_i),
      .last_grant (last_grant_q),
      .grant      (arb_onehot),
      .grant_idx  (arb_idx)
   );

   // Fold the unused high struct bits and the one-hot grant into a sink
   assign unused_bits = ^{req_q, arb_onehot};

`ifdef HYPERBUS_CFG_TIMEOUT_EN
   logic [15:0] tmo_cnt_q;
   logic        timeout_q;

   // The abort fires in the last allowed ISSUE cycle unless the macro answers then
   assign timeout_hit = (state_q == ISSUE) && !m_ready_i &&
                        (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // Count waiting ISSUE cycles; restart from zero whenever we are not issuing
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_hit;
         if (state_q != ISSUE) begin
            tmo_cnt_q <= '0;
         end else if (!m_ready_i) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   logic [15:0] unused_timeout_cycles;

   assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
   assign timeout_hit           = 1'b0;
   assign timeout_o             = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant in IDLE, wait for the macro in ISSUE, one-cycle RESP
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|s_valid_i) state_d = ISSUE;
         ISSUE:   if (m_ready_i || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Latch the granted request in IDLE and capture the response in ISSUE
   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         req_q        <= '0;
         last_grant_q <= IDX_W'(NR_PORTS - 1);
         resp_rdata_q <= '0;
         resp_error_q <= 1'b0;
      end else begin
         if (state_q == IDLE && (|s_valid_i)) begin
            req_q.addr   <= CFG_MAX_ADDR_WIDTH'(s_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH]);
            req_q.write  <= s_write_i[arb_idx];
            req_q.wdata  <= CFG_MAX_DATA_WIDTH'(s_wdata_i[arb_idx*DATA_WIDTH +: DATA_WIDTH]);
            req_q.wstrb  <= CFG_MAX_STRB_WIDTH'(s_wstrb_i[arb_idx*SW +: SW]);
            last_grant_q <= arb_idx;
         end
         if (state_q == ISSUE) begin
            if (m_ready_i) begin
               resp_rdata_q <= m_rdata_i;
               resp_error_q <= m_error_i;
            end else if (timeout_hit) begin
               resp_rdata_q <= '0;
               resp_error_q <= 1'b1;
            end
         end
      end
   end

   assign m_valid_o = (state_q == ISSUE);
   assign m_addr_o  = req_q.addr[ADDR_WIDTH-1:0];
   assign m_write_o = req_q.write;
   assign m_wdata_o = req_q.wdata[DATA_WIDTH-1:0];
   assign m_wstrb_o = req_q.wstrb[SW-1:0];

   // Route the captured response to the granted port only, during RESP
   always_comb begin
      s_ready_o = '0;
      s_error_o = '0;
      s_rdata_o = '0;
      if (state_q == RESP) begin
         s_ready_o[last_grant_q]                          = 1'b1;
         s_error_o[last_grant_q]                          = resp_error_q;
         s_rdata_o[last_grant_q*DATA_WIDTH +: DATA_WIDTH] = resp_rdata_q;
      end
   end

endmodule

// File: tb/tb_hyperbus_cfg_arbiter.sv
// Directed testbench for hyperbus_cfg_arbiter (two ports, 32-bit buses).
// Build with HYPERBUS_CFG_TIMEOUT_EN defined to exercise the timeout abort.
module tb_hyperbus_cfg_arbiter;

   localparam int NR_PORTS       = 2;
   localparam int ADDR_WIDTH     = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int SW             = DATA_WIDTH / 8;
   localparam int TIMEOUT_CYCLES = 8;

   logic                           clk_sys_i = 1'b0;
   logic                           rst_i;
   logic [NR_PORTS*ADDR_WIDTH-1:0] s_addr_i;
   logic [NR_PORTS-1:0]            s_write_i;
   logic [NR_PORTS*DATA_WIDTH-1:0] s_wdata_i;
   logic [NR_PORTS*SW-1:0]         s_wstrb_i;
   logic [NR_PORTS-1:0]            s_valid_i;
   logic [NR_PORTS*DATA_WIDTH-1:0] s_rdata_o;
   logic [NR_PORTS-1:0]            s_error_o;
   logic [NR_PORTS-1:0]            s_ready_o;
   logic [ADDR_WIDTH-1:0]          m_addr_o;
   logic                           m_write_o;
   logic [DATA_WIDTH-1:0]          m_wdata_o;
   logic [SW-1:0]                  m_wstrb_o;
   logic                           m_valid_o;
   logic [DATA_WIDTH-1:0]          m_rdata_i;
   logic                           m_error_i;
   logic                           m_ready_i;
   logic                           timeout_o;

   int assert_count = 0;
   int fail_count   = 0;

   hyperbus_cfg_arbiter #(
      .NR_PORTS       (NR_PORTS),
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk_sys_i (clk_sys_i),
      .rst_i     (rst_i),
      .s_addr_i  (s_addr_i),
      .s_write_i (s_write_i),
      .s_wdata_i (s_wdata_i),
      .s_wstrb_i (s_wstrb_i),
      .s_valid_i (s_valid_i),
      .s_rdata_o (s_rdata_o),
      .s_error_o (s_error_o),
      .s_ready_o (s_ready_o),
      .m_addr_o  (m_addr_o),
      .m_write_o (m_write_o),
      .m_wdata_o (m_wdata_o),
      .m_wstrb_o (m_wstrb_o),
      .m_valid_o (m_valid_o),
      .m_rdata_i (m_rdata_i),
      .m_error_i (m_error_i),
      .m_ready_i (m_ready_i),
      .timeout_o (timeout_o)
   );

   // Free-running 100 MHz clock
   always #5 clk_sys_i = ~clk_sys_i;

   // Watchdog so the run always ends even if the flow below stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk_sys_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present a request on one port and raise its valid
   task automatic applyStimulus(input int port, input logic write,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb);
      s_addr_i[port*ADDR_WIDTH +: ADDR_WIDTH]  = addr;
      s_write_i[port]                          = write;
      s_wdata_i[port*DATA_WIDTH +: DATA_WIDTH] = wdata;
      s_wstrb_i[port*SW +: SW]                 = wstrb;
      s_valid_i[port]                          = 1'b1;
   endtask

   task automatic resetDut();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Wait (bounded) for the downstream request to appear; returns edges waited
   task automatic waitIssue(input string tag, output int cycles);
      cycles = 0;
      while (m_valid_o !== 1'b1 && cycles < 50) begin
         tick();
         cycles++;
      end
      checkOutput({tag, "_issue"}, 64'(m_valid_o), 64'd1);
   endtask

   // Hold off the macro for some cycles, then answer for exactly one cycle
   task automatic respond(input int delay, input logic [31:0] rdata, input logic err);
      repeat (delay) tick();
      m_ready_i = 1'b1;
      m_rdata_i = rdata;
      m_error_i = err;
      tick();
      m_ready_i = 1'b0;
      m_rdata_i = '0;
      m_error_i = 1'b0;
   endtask

   int cyc;
   int vcycles;
   logic tmo_seen;
   logic [31:0] exp_addr;

   initial begin
      rst_i     = 1'b1;
      s_addr_i  = '0;
      s_write_i = '0;
      s_wdata_i = '0;
      s_wstrb_i = '0;
      s_valid_i = '0;
      m_rdata_i = '0;
      m_error_i = 1'b0;
      m_ready_i = 1'b0;
      $display("[TB] start");

      // Reset values
      resetDut();
      checkOutput("rst_m_valid", 64'(m_valid_o), 64'd0);
      checkOutput("rst_s_ready", 64'(s_ready_o), 64'd0);
      checkOutput("rst_s_rdata", 64'(s_rdata_o), 64'd0);
      checkOutput("rst_m_addr",  64'(m_addr_o),  64'd0);
      checkOutput("rst_timeout", 64'(timeout_o), 64'd0);

      // Single read on port 0, macro answers one cycle after m_valid
      applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0);
      waitIssue("rd0", cyc);
      checkOutput("rd0_grant_lat", 64'(cyc), 64'd1);
      checkOutput("rd0_m_addr", 64'(m_addr_o), 64'h10);
      checkOutput("rd0_m_write", 64'(m_write_o), 64'd0);
      respond(1, 32'hDEADBEEF, 1'b0);
      cyc = cyc + 2 + 1;
      checkOutput("rd0_total_cycles", 64'(cyc), 64'd4);
      checkOutput("rd0_s_ready", 64'(s_ready_o), 64'h1);
      checkOutput("rd0_s_rdata", 64'(s_rdata_o), 64'h0000_0000_DEAD_BEEF);
      checkOutput("rd0_s_error", 64'(s_error_o), 64'd0);
      checkOutput("rd0_m_valid_resp", 64'(m_valid_o), 64'd0);
      s_valid_i[0] = 1'b0;
      tick();
      checkOutput("rd0_ready_pulse", 64'(s_ready_o), 64'd0);

      // Round-robin alternation with both ports continuously requesting
      resetDut();
      applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0);
      applyStimulus(1, 1'b0, 32'h2000, 32'h0, 4'h0);
      for (int k = 0; k < 4; k++) begin
         waitIssue($sformatf("rr%0d", k), cyc);
         exp_addr = (k % 2 == 0) ? 32'h1000 : 32'h2000;
         checkOutput($sformatf("rr%0d_m_addr", k), 64'(m_addr_o), 64'(exp_addr));
         respond(0, 32'h100 + 32'(k), 1'b0);
         checkOutput($sformatf("rr%0d_s_ready", k), 64'(s_ready_o),
                     (k % 2 == 0) ? 64'h1 : 64'h2);
         checkOutput($sformatf("rr%0d_s_rdata", k), 64'(s_rdata_o),
                     (k % 2 == 0) ? 64'(32'h100 + 32'(k)) : {32'h100 + 32'(k), 32'h0});
         tick();
         checkOutput($sformatf("rr%0d_idle_m_valid", k), 64'(m_valid_o), 64'd0);
      end
      s_valid_i = '0;
      tick();
      tick();

      // Write with downstream error on port 1
      applyStimulus(1, 1'b1, 32'h3000, 32'hA5A5A5A5, 4'h3);
      waitIssue("wr1", cyc);
      checkOutput("wr1_m_write", 64'(m_write_o), 64'd1);
      checkOutput("wr1_m_wdata", 64'(m_wdata_o), 64'hA5A5A5A5);
      checkOutput("wr1_m_wstrb", 64'(m_wstrb_o), 64'h3);
      checkOutput("wr1_m_addr",  64'(m_addr_o),  64'h3000);
      respond(2, 32'h0, 1'b1);
      checkOutput("wr1_s_ready", 64'(s_ready_o), 64'h2);
      checkOutput("wr1_s_error", 64'(s_error_o), 64'h2);
      checkOutput("wr1_s_rdata", 64'(s_rdata_o), 64'd0);
      s_valid_i = '0;
      tick();

      // Requester drops valid mid-access; a late request from port 1 must wait
      applyStimulus(0, 1'b0, 32'h4000, 32'h0, 4'h0);
      waitIssue("drop0", cyc);
      s_valid_i[0] = 1'b0;
      applyStimulus(1, 1'b0, 32'h5000, 32'h0, 4'h0);
      tick();
      checkOutput("drop0_m_valid_held", 64'(m_valid_o), 64'd1);
      checkOutput("drop0_m_addr_stable", 64'(m_addr_o), 64'h4000);
      respond(0, 32'hCAFE0000, 1'b0);
      checkOutput("drop0_s_ready", 64'(s_ready_o), 64'h1);
      checkOutput("drop0_s_rdata", 64'(s_rdata_o), 64'h0000_0000_CAFE_0000);
      tick();
      checkOutput("late1_not_in_resp", 64'(m_valid_o), 64'd0);
      waitIssue("late1", cyc);
      checkOutput("late1_m_addr", 64'(m_addr_o), 64'h5000);
      respond(0, 32'h1, 1'b0);
      checkOutput("late1_s_ready", 64'(s_ready_o), 64'h2);
      s_valid_i = '0;
      tick();

      // Reset while ISSUE is active; afterwards port 0 wins again
      applyStimulus(0, 1'b1, 32'h6000, 32'h11, 4'hF);
      waitIssue("rstmid", cyc);
      checkOutput("rstmid_m_addr", 64'(m_addr_o), 64'h6000);
      rst_i = 1'b1;
      applyStimulus(1, 1'b0, 32'h6100, 32'h0, 4'h0);
      tick();
      rst_i = 1'b0;
      checkOutput("rstmid_m_valid", 64'(m_valid_o), 64'd0);
      checkOutput("rstmid_s_ready", 64'(s_ready_o), 64'd0);
      checkOutput("rstmid_m_addr_clr", 64'(m_addr_o), 64'd0);
      checkOutput("rstmid_m_wdata_clr", 64'(m_wdata_o), 64'd0);
      checkOutput("rstmid_m_write_clr", 64'(m_write_o), 64'd0);
      waitIssue("postrst", cyc);
      checkOutput("postrst_m_addr", 64'(m_addr_o), 64'h6000);
      respond(0, 32'h22, 1'b0);
      checkOutput("postrst_s_ready", 64'(s_ready_o), 64'h1);
      s_valid_i = '0;
      tick();
      tick();

`ifdef HYPERBUS_CFG_TIMEOUT_EN
      // Macro never answers: abort after TIMEOUT_CYCLES issue cycles
      applyStimulus(0, 1'b0, 32'h8000, 32'h0, 4'h0);
      m_rdata_i = 32'hFFFF_FFFF;
      waitIssue("tmo", cyc);
      vcycles = 1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (m_valid_o !== 1'b1) break;
         vcycles++;
      end
      checkOutput("tmo_valid_cycles", 64'(vcycles), 64'd8);
      checkOutput("tmo_pulse", 64'(timeout_o), 64'd1);
      checkOutput("tmo_s_ready", 64'(s_ready_o), 64'h1);
      checkOutput("tmo_s_error", 64'(s_error_o), 64'h1);
      checkOutput("tmo_s_rdata", 64'(s_rdata_o), 64'd0);
      s_valid_i = '0;
      m_rdata_i = '0;
      tick();
      checkOutput("tmo_pulse_end", 64'(timeout_o), 64'd0);

      // Macro answers in the very last allowed cycle: normal completion
      applyStimulus(1, 1'b0, 32'h9000, 32'h0, 4'h0);
      waitIssue("tmolast", cyc);
      respond(7, 32'h600D, 1'b0);
      checkOutput("tmolast_s_ready", 64'(s_ready_o), 64'h2);
      checkOutput("tmolast_no_pulse", 64'(timeout_o), 64'd0);
      checkOutput("tmolast_s_error", 64'(s_error_o), 64'd0);
      checkOutput("tmolast_s_rdata", 64'(s_rdata_o), {32'h600D, 32'h0});
      s_valid_i = '0;
      tick();
`else
      // Without the timeout feature the access waits indefinitely
      applyStimulus(0, 1'b0, 32'h7000, 32'h0, 4'h0);
      waitIssue("notmo", cyc);
      tmo_seen = 1'b0;
      repeat (20) begin
         tick();
         if (timeout_o !== 1'b0) tmo_seen = 1'b1;
      end
      checkOutput("notmo_m_valid", 64'(m_valid_o), 64'd1);
      checkOutput("notmo_pulse", 64'(tmo_seen), 64'd0);
      respond(0, 32'h77, 1'b0);
      checkOutput("notmo_s_ready", 64'(s_ready_o), 64'h1);
      checkOutput("notmo_s_rdata", 64'(s_rdata_o), 64'h77);
      s_valid_i = '0;
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
